// File: rtl/comparator_bist.sv
// Built-in self-test sequencer for a combinational magnitude comparator.
// Sweeps all (A,B) operand pairs, samples gt/lt/eq after a settle time, and records failures.
module comparator_bist #(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               gt_in,
   input  logic               lt_in,
   input  logic               eq_in,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               first_fail_valid,
   output logic [WIDTH-1:0]   first_fail_a,
   output logic [WIDTH-1:0]   first_fail_b
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int VW = 2 * WIDTH;
   localparam logic [CW-1:0]      CNT_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [VW-1:0]      VEC_ONE  = {{(VW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   OP_ZERO  = {WIDTH{1'b0}};
   localparam logic [2*WIDTH:0]   ERR_ZERO = {(2*WIDTH+1){1'b0}};
   localparam logic [2*WIDTH:0]   ERR_ONE  = {{(2*WIDTH){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [CW-1:0]        cnt_r, cnt_s;
   logic [WIDTH-1:0]     a_s, b_s, ffa_s, ffb_s;
   logic                 busy_s, done_s, pass_s, ffv_s;
   logic [2*WIDTH:0]     err_s;
   logic                 last_vec_s;
   logic                 mismatch_s;

   // A vector fails when any flag disagrees; several wrong flags still count once.
   function automatic logic cmp_error(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic gt, input logic lt, input logic eq);
      return (gt != (a > b)) || (lt != (a < b)) || (eq != (a == b));
   endfunction

   assign last_vec_s = &{a_out, b_out};
   assign mismatch_s = cmp_error(a_out, b_out, gt_in, lt_in, eq_in);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   if (start) state_s = ST_SETTLE; else state_s = ST_IDLE;
         ST_SETTLE: if (cnt_r == CNT_LAST) state_s = ST_CHECK; else state_s = ST_SETTLE;
         ST_CHECK:  if (last_vec_s) state_s = ST_DONE; else state_s = ST_SETTLE;
         ST_DONE:   state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and the settle counter
   always_comb begin
      cnt_s  = cnt_r;
      a_s    = a_out;
      b_s    = b_out;
      busy_s = busy;
      done_s = 1'b0;
      pass_s = pass;
      err_s  = err_count;
      ffv_s  = first_fail_valid;
      ffa_s  = first_fail_a;
      ffb_s  = first_fail_b;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               a_s    = OP_ZERO;
               b_s    = OP_ZERO;
               err_s  = ERR_ZERO;
               ffv_s  = 1'b0;
               ffa_s  = OP_ZERO;
               ffb_s  = OP_ZERO;
               pass_s = 1'b0;
               busy_s = 1'b1;
               cnt_s  = CNT_ZERO;
            end else begin
               cnt_s  = cnt_r;
            end
         end
         ST_SETTLE: cnt_s = cnt_r + CNT_ONE;
         ST_CHECK: begin
            if (mismatch_s) begin
               err_s = err_count + ERR_ONE;
               if (!first_fail_valid) begin
                  ffv_s = 1'b1;
                  ffa_s = a_out;
                  ffb_s = b_out;
               end else begin
                  ffv_s = first_fail_valid;
               end
            end else begin
               err_s = err_count;
            end
            // DONE-cycle outputs are loaded here so they are visible during DONE.
            if (last_vec_s) begin
               done_s = 1'b1;
               busy_s = 1'b0;
               pass_s = (err_s == ERR_ZERO);
            end else begin
               {a_s, b_s} = {a_out, b_out} + VEC_ONE;
               cnt_s      = CNT_ZERO;
            end
         end
         ST_DONE: done_s = 1'b0;
         default: done_s = 1'b0;
      endcase
   end

   // Output and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r            <= CNT_ZERO;
         a_out            <= OP_ZERO;
         b_out            <= OP_ZERO;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= ERR_ZERO;
         first_fail_valid <= 1'b0;
         first_fail_a     <= OP_ZERO;
         first_fail_b     <= OP_ZERO;
      end else begin
         cnt_r            <= cnt_s;
         a_out            <= a_s;
         b_out            <= b_s;
         busy             <= busy_s;
         done             <= done_s;
         pass             <= pass_s;
         err_count        <= err_s;
         first_fail_valid <= ffv_s;
         first_fail_a     <= ffa_s;
         first_fail_b     <= ffb_s;
      end
   end

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (2-bit/settle 1, 3-bit/settle 3) against a timing-rule model
// of the sweep, with a fault-injectable comparator model feeding the flags.
module tb_comparator_bist;
   localparam int W0 = 2, S0 = 1, W1 = 3, S1 = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [W0-1:0] a0, b0, ffa0, ffb0;
   logic [W1-1:0] a1, b1, ffa1, ffb1;
   logic busy0, done0, pass0, ffv0, gt0, lt0, eq0;
   logic busy1, done1, pass1, ffv1, gt1, lt1, eq1;
   logic [2*W0:0] err0;
   logic [2*W1:0] err1;

   // Fault mode per instance: 0 good, 1 gt stuck 0, 2 eq inverted, 3 gt and eq forced 1
   int mode [2];
   int nchk = 0, nerr = 0;

   // Expected-behaviour model state, indexed by instance
   int wd [2] = '{W0, W1};
   int sd [2] = '{S0, S1};
   int ph [2], t [2], ea [2], eb [2], ebusy [2], edone [2], epass [2];
   int eerr [2], effv [2], effa [2], effb [2], st_l [2];
   logic [2:0] fl_l [2];

   always #5 clk = ~clk;

   comparator_bist #(.WIDTH(W0), .SETTLE(S0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .gt_in(gt0), .lt_in(lt0), .eq_in(eq0),
      .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_fail_valid(ffv0), .first_fail_a(ffa0), .first_fail_b(ffb0));

   comparator_bist #(.WIDTH(W1), .SETTLE(S1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .gt_in(gt1), .lt_in(lt1), .eq_in(eq1),
      .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_valid(ffv1), .first_fail_a(ffa1), .first_fail_b(ffb1));

   function automatic logic [2:0] cmp_model(input int m, input int a, input int b);
      logic g, l, e;
      g = (a > b); l = (a < b); e = (a == b);
      if (m == 1) g = 1'b0;
      else if (m == 2) e = !e;
      else if (m == 3) begin g = 1'b1; e = 1'b1; end
      return {g, l, e};
   endfunction

   always_comb begin
      {gt0, lt0, eq0} = cmp_model(mode[0], int'(a0), int'(b0));
      {gt1, lt1, eq1} = cmp_model(mode[1], int'(a1), int'(b1));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         if (nerr <= 40) $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One edge of the sweep, derived from elapsed cycles since the accepted start
   task automatic model_step(input int id);
      int p, n, k, a, b;
      logic [2:0] ex;
      p = sd[id] + 1;
      n = 1 << (2 * wd[id]);
      case (ph[id])
         0: if (st_l[id] != 0) begin
               ph[id] = 1; t[id] = 0; ea[id] = 0; eb[id] = 0; eerr[id] = 0;
               effv[id] = 0; effa[id] = 0; effb[id] = 0; epass[id] = 0; ebusy[id] = 1;
            end
         1: begin
               if (t[id] % p == p - 1) begin
                  k = t[id] / p;
                  a = k >> wd[id];
                  b = k % (1 << wd[id]);
                  ex = {(a > b), (a < b), (a == b)};
                  if (fl_l[id] != ex) begin
                     eerr[id]++;
                     if (effv[id] == 0) begin effv[id] = 1; effa[id] = a; effb[id] = b; end
                  end
                  if (k == n - 1) begin
                     ph[id] = 2; edone[id] = 1; ebusy[id] = 0; epass[id] = (eerr[id] == 0);
                  end
               end
               if (ph[id] == 1) begin
                  t[id]++;
                  ea[id] = (t[id] / p) >> wd[id];
                  eb[id] = (t[id] / p) % (1 << wd[id]);
               end
            end
         2: begin ph[id] = 0; edone[id] = 0; end
         default: ph[id] = 0;
      endcase
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      for (int id = 0; id < 2; id++) begin
         if (rst) begin
            ph[id] = 0; t[id] = 0; ea[id] = 0; eb[id] = 0; ebusy[id] = 0; edone[id] = 0;
            epass[id] = 0; eerr[id] = 0; effv[id] = 0; effa[id] = 0; effb[id] = 0;
         end else begin
            model_step(id);
         end
      end
   end

   task automatic cmp_dut(input int id, input logic [31:0] a, b, busy, done, pass, err, ffv, ffa, ffb);
      chk($sformatf("d%0d.a_out", id), a, ea[id]);
      chk($sformatf("d%0d.b_out", id), b, eb[id]);
      chk($sformatf("d%0d.busy", id), busy, ebusy[id]);
      chk($sformatf("d%0d.done", id), done, edone[id]);
      chk($sformatf("d%0d.pass", id), pass, epass[id]);
      chk($sformatf("d%0d.err_count", id), err, eerr[id]);
      chk($sformatf("d%0d.ff_valid", id), ffv, effv[id]);
      chk($sformatf("d%0d.ff_a", id), ffa, effa[id]);
      chk($sformatf("d%0d.ff_b", id), ffb, effb[id]);
   endtask

   // Compare every cycle on the falling edge and latch the inputs the next rising edge will see
   initial forever begin
      @(negedge clk);
      st_l[0] = int'(start0);
      st_l[1] = int'(start1);
      fl_l[0] = {gt0, lt0, eq0};
      fl_l[1] = {gt1, lt1, eq1};
      cmp_dut(0, a0, b0, busy0, done0, pass0, err0, ffv0, ffa0, ffb0);
      cmp_dut(1, a1, b1, busy1, done1, pass1, err1, ffv1, ffa1, ffb1);
   end

   // Called at posedge+1; optionally pulses start, then counts edges until done (bounded)
   task automatic run_sweep(input int id, input int do_start, input int repulse, output int cyc);
      if (do_start != 0) begin
         if (id == 0) start0 = 1'b1; else start1 = 1'b1;
         @(posedge clk); #1;
         start0 = 1'b0; start1 = 1'b0;
      end
      cyc = 0;
      while (cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (id == 0) start0 = (cyc == repulse); else start1 = (cyc == repulse);
         if ((id == 0 && done0) || (id == 1 && done1)) break;
      end
      start0 = 1'b0; start1 = 1'b0;
   endtask

   initial begin
      int cyc, n;
      mode[0] = 0; mode[1] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst.busy0", busy0, 0);
      chk("rst.err0", err0, 0);
      chk("rst.a1", a1, 0);

      run_sweep(0, 1, -1, cyc);
      chk("good.cycles", cyc, 32);
      chk("good.pass", pass0, 1);
      chk("good.err", err0, 0);
      chk("good.ffv", ffv0, 0);
      @(posedge clk); #1;

      mode[0] = 1;
      run_sweep(0, 1, -1, cyc);
      chk("gt0.err", err0, 6);
      chk("gt0.pass", pass0, 0);
      chk("gt0.ffv", ffv0, 1);
      chk("gt0.ffa", ffa0, 1);
      chk("gt0.ffb", ffb0, 0);
      @(posedge clk); #1;

      mode[0] = 2;
      run_sweep(0, 1, -1, cyc);
      chk("eqinv.err", err0, 16);
      chk("eqinv.ffa", ffa0, 0);
      chk("eqinv.ffb", ffb0, 0);
      @(posedge clk); #1;

      mode[0] = 3;
      run_sweep(0, 1, -1, cyc);
      chk("gteq1.err", err0, 16);
      @(posedge clk); #1;

      mode[0] = 0;
      run_sweep(0, 1, 10, cyc);
      chk("repulse.cycles", cyc, 32);
      chk("repulse.pass", pass0, 1);
      // start held through DONE is ignored there and accepted in the next IDLE cycle
      start0 = 1'b1;
      @(posedge clk); #1;
      chk("donestart.idle", busy0, 0);
      @(posedge clk); #1;
      chk("donestart.accept", busy0, 1);
      start0 = 1'b0;
      run_sweep(0, 0, -1, cyc);
      chk("donestart.cycles", cyc, 32);
      @(posedge clk); #1;

      // Asynchronous reset while the sweep sits at vector (1,1)
      mode[0] = 1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (!(a0 == 2'd1 && b0 == 2'd1) && n < 50) begin @(posedge clk); #1; n++; end
      chk("arst.reach", n, 10);
      chk("arst.err_before", err0, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst.a", a0, 0);
      chk("arst.b", b0, 0);
      chk("arst.busy", busy0, 0);
      chk("arst.err", err0, 0);
      chk("arst.ffv", ffv0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mode[0] = 0;
      run_sweep(0, 1, -1, cyc);
      chk("arst.sweep_cycles", cyc, 32);
      chk("arst.sweep_pass", pass0, 1);
      @(posedge clk); #1;

      mode[1] = 1;
      run_sweep(1, 1, -1, cyc);
      chk("w3.cycles", cyc, 256);
      chk("w3.err", err1, 28);
      chk("w3.ffa", ffa1, 1);
      chk("w3.ffb", ffb1, 0);
      chk("w3.pass", pass1, 0);
      @(posedge clk); #1;
      mode[1] = 0;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("w3.err_cleared", err1, 0);
      chk("w3.ffv_cleared", ffv1, 0);
      run_sweep(1, 0, -1, cyc);
      chk("w3b.cycles", cyc, 256);
      chk("w3b.pass", pass1, 1);
      chk("w3b.err", err1, 0);

      // Random start traffic and fault modes, checked cycle by cycle against the model
      repeat (700) begin
         @(posedge clk); #1;
         start0 = ($urandom_range(0, 7) == 0);
         start1 = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 40) == 0) mode[0] = int'($urandom_range(0, 3));
         if ($urandom_range(0, 40) == 0) mode[1] = int'($urandom_range(0, 3));
      end
      start0 = 1'b0; start1 = 1'b0;
      mode[0] = 0; mode[1] = 0;
      repeat (300) @(posedge clk);
      #1;
      chk("end.idle0", busy0, 0);
      chk("end.idle1", busy1, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
